// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot2(input logic [1:0] idx);
    onehot2 = 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// Combinational wrap-around search: first set bit of i_vec at or after i_start.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  input  logic [1:0]       i_start,
  output logic             o_found,
  output logic [1:0]       o_idx
);

  // Walk from the farthest offset down so the nearest hit is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_start;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      logic [1:0] w_pos;
      w_pos = i_start + 2'(k);
      if (i_vec[w_pos]) begin
        o_found = 1'b1;
        o_idx   = w_pos;
      end
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a bounded hold, driving a 4->1 mux select.
module rr_arb4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             gnt_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state;
  logic [1:0]       r_last, w_last;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic [1:0]       r_sel, w_sel;
  logic             r_vld, w_vld;

  logic [N_REQ-1:0] w_own_oh;
  logic [N_REQ-1:0] w_pick_vec;
  logic             w_own_req;
  logic             w_at_limit;
  logic             w_found;
  logic [1:0]       w_idx;

  // While granting, the owner is masked out so the search only finds a successor.
  assign w_own_oh   = onehot2(r_last);
  assign w_pick_vec = (r_state == GRANT) ? (req & ~w_own_oh) : req;
  assign w_own_req  = |(req & w_own_oh);
  assign w_at_limit = (MAX_HOLD != 0) && (r_cnt == CNT_MAX);

  rr_pick4 u_pick (
    .i_vec   (w_pick_vec),
    .i_start (r_last + 2'd1),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_state = r_state;
    w_last  = r_last;
    w_cnt   = r_cnt;
    w_gnt   = r_gnt;
    w_sel   = r_sel;
    w_vld   = r_vld;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state = GRANT;
          w_last  = w_idx;
          w_cnt   = CNT_ONE;
          w_gnt   = onehot2(w_idx);
          w_sel   = w_idx;
          w_vld   = 1'b1;
        end
      end
      GRANT: begin
        if ((!w_own_req || w_at_limit) && w_found) begin
          w_last = w_idx;
          w_cnt  = CNT_ONE;
          w_gnt  = onehot2(w_idx);
          w_sel  = w_idx;
        end else if (!w_own_req) begin
          w_state = IDLE;
          w_gnt   = '0;
          w_vld   = 1'b0;
        end else if (w_at_limit) begin
          w_cnt = CNT_ONE;
        end else if (MAX_HOLD != 0) begin
          w_cnt = r_cnt + CNT_ONE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_sel   <= 2'd0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_vld   <= w_vld;
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign gnt_valid = r_vld;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_valid  : assert property (@(posedge clk) disable iff (rst) gnt_valid == (|gnt));
  a_sel    : assert property (@(posedge clk) disable iff (rst) gnt_valid |-> (gnt == onehot2(sel)));
  a_selchg : assert property (@(posedge clk) disable iff (rst)
                              (sel != $past(sel)) |-> (gnt_valid && (!$past(gnt_valid) || gnt != $past(gnt))));

endmodule
